// File: rtl/sid_sched_pkg.sv
// Shared types and frame-length helpers for the SID pipeline scheduler.
// Pure declarations; no timing or flow control.
package sid_sched_pkg;

    typedef logic [4:0] sched_cycle_t;

    localparam int SID_MAX = 4;

    // Last voice-pipeline cycle of a phi2 frame for n time-multiplexed SIDs.
    function automatic int vlast(input int n);
        return 6 + 6 * n;
    endfunction

    // Last filter-pipeline cycle for n SIDs with fw filter cycles per SID window.
    function automatic int flast(input int n, input int fw);
        return fw * n + 4;
    endfunction

endpackage

// File: rtl/sid_sched_cnt.sv
// Voice/filter pipeline cycle counters, stall decode and sticky overrun; counts are registered, outputs follow the registers combinationally.
// No backpressure: phi2 falling edges always restart the voice pipeline.
module sid_sched_cnt
    import sid_sched_pkg::*;
#(
    parameter int NUM_SID = 2,
    parameter int FW      = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         phi2,
    output sched_cycle_t voice_cycle,
    output sched_cycle_t filter_cycle,
    output logic         overrun
);

    localparam sched_cycle_t VLAST = sched_cycle_t'(vlast(NUM_SID));
    localparam sched_cycle_t FLAST = sched_cycle_t'(flast(NUM_SID, FW));

    logic         phi2_prev_q;
    sched_cycle_t vcnt_q, vcnt_d;
    sched_cycle_t fcnt_q, fcnt_d;
    logic         overrun_q, overrun_d;
    logic         stall;
    logic         fall;

    // Voice holds for two cycles inside each SID window except the last, letting filters catch up.
    always_comb begin
        stall = 1'b0;
        for (int k = 0; k < NUM_SID - 1; k++) begin
            if (fcnt_q == sched_cycle_t'(FW * k + 4) || fcnt_q == sched_cycle_t'(FW * k + 5)) begin
                stall = 1'b1;
            end
        end
    end

    assign fall         = phi2_prev_q & ~phi2;
    assign voice_cycle  = stall ? '0 : vcnt_q;
    assign filter_cycle = fcnt_q;
    assign overrun      = overrun_q;

    always_comb begin
        vcnt_d    = vcnt_q;
        overrun_d = overrun_q;
        if (fall) begin
            vcnt_d = 5'd1;
            if (vcnt_q != '0) begin
                overrun_d = 1'b1;
            end
        end else if (vcnt_q == VLAST) begin
            vcnt_d = '0;
        end else if (vcnt_q != '0 && !stall) begin
            vcnt_d = vcnt_q + 5'd1;
        end

        fcnt_d = fcnt_q;
        if (fcnt_q == FLAST) begin
            fcnt_d = '0;
        end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q + 5'd1;
        end else if (voice_cycle == 5'd6) begin
            fcnt_d = 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_prev_q <= 1'b0;
            vcnt_q      <= '0;
            fcnt_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            phi2_prev_q <= phi2;
            vcnt_q      <= vcnt_d;
            fcnt_q      <= fcnt_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: rtl/sid_sched.sv
// SID pipeline scheduler: cycle numbering, OSC3/ENV3 capture and readback, audio frame assembly (audio_o/audio_valid one clk after the last slot).
// No backpressure: audio_valid is a single-cycle pulse that downstream must accept.
module sid_sched
    import sid_sched_pkg::*;
#(
    parameter int NUM_SID   = 2,
    parameter int FW        = 5,
    parameter int TICK_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  phi2,
    input  logic [NUM_SID-1:0]    sid_cs,
    input  logic [11:0]           wav,
    input  logic [7:0]            env,
    input  logic [19:0]           filter_o,
    output logic [4:0]            voice_cycle,
    output logic [4:0]            filter_cycle,
    output logic                  tick_ms,
    output logic [7:0]            osc3_o,
    output logic [7:0]            env3_o,
    output logic [24*NUM_SID-1:0] audio_o,
    output logic                  audio_valid,
    output logic                  overrun
);

    if (NUM_SID < 1 || NUM_SID > SID_MAX) begin : g_bad_num_sid
        $error("sid_sched: NUM_SID out of range");
    end

    localparam sched_cycle_t LAST_SLOT = sched_cycle_t'(9 + FW * (NUM_SID - 1));

    sched_cycle_t voice_cyc, filter_cyc;

    sid_sched_cnt #(
        .NUM_SID (NUM_SID),
        .FW      (FW)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .phi2         (phi2),
        .voice_cycle  (voice_cyc),
        .filter_cycle (filter_cyc),
        .overrun      (overrun)
    );

    assign voice_cycle  = voice_cyc;
    assign filter_cycle = filter_cyc;

    logic [TICK_BITS-1:0] tick_q;

    assign tick_ms = (voice_cyc == 5'd1) & (&tick_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else if (voice_cyc == 5'd1) begin
            tick_q <= tick_q + 1'b1;
        end
    end

    logic [7:0] osc3_q [NUM_SID];
    logic [7:0] env3_q [NUM_SID];
    logic       wav_unused;

    assign wav_unused = ^wav[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SID; k++) begin
                osc3_q[k] <= '0;
                env3_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SID; k++) begin
                if (voice_cyc == sched_cycle_t'(8 + 3 * k)) begin
                    osc3_q[k] <= wav[11:4];
                    env3_q[k] <= env;
                end
            end
        end
    end

    // Descending scan so the lowest selected SID is the final assignment.
    always_comb begin
        osc3_o = osc3_q[0];
        env3_o = env3_q[0];
        for (int k = NUM_SID - 1; k >= 0; k--) begin
            if (sid_cs[k]) begin
                osc3_o = osc3_q[k];
                env3_o = env3_q[k];
            end
        end
    end

    logic [23:0]            stage_q [NUM_SID];
    logic [24*NUM_SID-1:0]  frame;
    logic [24*NUM_SID-1:0]  audio_q;
    logic                   valid_q;

    // The last slot bypasses staging so the whole frame lands in audio_q on one edge.
    always_comb begin
        frame = '0;
        for (int k = 0; k < NUM_SID; k++) begin
            frame[24*(NUM_SID-1-k) +: 24] = (k == NUM_SID - 1) ? {filter_o, 4'h0} : stage_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SID; k++) begin
                stage_q[k] <= '0;
            end
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            for (int k = 0; k < NUM_SID; k++) begin
                if (filter_cyc == sched_cycle_t'(9 + FW * k)) begin
                    stage_q[k] <= {filter_o, 4'h0};
                end
            end
            if (filter_cyc == LAST_SLOT) begin
                audio_q <= frame;
                valid_q <= 1'b1;
            end
        end
    end

    assign audio_o     = audio_q;
    assign audio_valid = valid_q;

endmodule

// File: tb/tb_sid_sched.sv
// Bench for sid_sched with NUM_SID=2 and NUM_SID=4 instances; expectations are queued by stimulus and consumed by negedge monitors.
module tb_sid_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, phi2_2, phi2_4;
    logic [1:0]  sid_cs2;
    logic [3:0]  sid_cs4;
    logic [11:0] wav;
    logic [7:0]  env;
    logic [19:0] filter_o;

    logic [4:0]  v2, f2, v4, f4;
    logic        tick2, tick4, av2, av4, ovr2, ovr4;
    logic [7:0]  osc2, envo2, osc4, envo4;
    logic [47:0] audio2;
    logic [95:0] audio4;

    sid_sched #(.NUM_SID(2), .FW(5), .TICK_BITS(10)) u2 (
        .clk(clk), .rst(rst), .phi2(phi2_2), .sid_cs(sid_cs2), .wav(wav), .env(env),
        .filter_o(filter_o), .voice_cycle(v2), .filter_cycle(f2), .tick_ms(tick2),
        .osc3_o(osc2), .env3_o(envo2), .audio_o(audio2), .audio_valid(av2), .overrun(ovr2)
    );

    sid_sched #(.NUM_SID(4), .FW(5), .TICK_BITS(10)) u4 (
        .clk(clk), .rst(rst), .phi2(phi2_4), .sid_cs(sid_cs4), .wav(wav), .env(env),
        .filter_o(filter_o), .voice_cycle(v4), .filter_cycle(f4), .tick_ms(tick4),
        .osc3_o(osc4), .env3_o(envo4), .audio_o(audio4), .audio_valid(av4), .overrun(ovr4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0] v;
        logic [4:0] f;
    } trace_t;

    typedef struct packed {
        logic [95:0] d;
        logic [4:0]  pf;
    } aud_t;

    trace_t tq2[$], tq4[$];
    aud_t   aq2[$], aq4[$];

    // Hand-derived per-cycle traces starting the cycle after the phi2 fall is detected.
    logic [4:0] V2_TAB [22] = '{1,2,3,4,5,6,7,8,9,0,0,10,11,12,13,14,15,16,17,18,0,0};
    logic [4:0] F2_TAB [22] = '{0,0,0,0,0,0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,0,0};
    logic [4:0] V4_TAB [37] = '{1,2,3,4,5,6,7,8,9,0,0,10,11,12,0,0,13,14,15,0,0,
                                16,17,18,19,20,21,22,23,24,25,26,27,28,29,30,0};
    logic [4:0] F4_TAB [37] = '{0,0,0,0,0,0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16,17,18,19,20,21,22,23,24,
                                0,0,0,0,0,0,0};

    logic [4:0] pf2, pf4;
    trace_t     t2, t4;
    aud_t       a2, a4;

    always @(negedge clk) begin
        if (tq2.size() > 0) begin
            t2 = tq2.pop_front();
            check("trace2_voice", v2, t2.v);
            check("trace2_filter", f2, t2.f);
        end
        if (av2 === 1'b1) begin
            if (aq2.size() == 0) begin
                checks++; errors++;
                $display("FAIL audio2_unexpected: audio_valid got 1 expected 0 (audio_o %0h)", audio2);
            end else begin
                a2 = aq2.pop_front();
                check("audio2_data", audio2, a2.d);
                check("audio2_after_slot", pf2, a2.pf);
            end
        end
        pf2 = f2;
    end

    always @(negedge clk) begin
        if (tq4.size() > 0) begin
            t4 = tq4.pop_front();
            check("trace4_voice", v4, t4.v);
            check("trace4_filter", f4, t4.f);
        end
        if (av4 === 1'b1) begin
            if (aq4.size() == 0) begin
                checks++; errors++;
                $display("FAIL audio4_unexpected: audio_valid got 1 expected 0 (audio_o %0h)", audio4);
            end else begin
                a4 = aq4.pop_front();
                check("audio4_data", audio4, a4.d);
                check("audio4_after_slot", pf4, a4.pf);
            end
        end
        pf4 = f4;
    end

    logic tick_en = 1'b0;
    int   starts = 0, tick_cnt = 0, tick_at = 0, bad_tick = 0;

    always @(negedge clk) begin
        if (tick_en) begin
            if (v2 == 5'd1) starts++;
            if (tick2 === 1'b1) begin
                tick_cnt++;
                tick_at = starts;
                if (v2 != 5'd1) bad_tick++;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; phi2_2 = 1'b1; phi2_4 = 1'b1;
        sid_cs2 = '0; sid_cs4 = '0;
        wav = '0; env = '0; filter_o = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_voice2", v2, 0);
        check("rst_filter2", f2, 0);
        check("rst_audio2", audio2, 0);
        check("rst_valid2", av2, 0);
        check("rst_overrun2", ovr2, 0);
        check("rst_tick2", tick2, 0);
        check("rst_osc2", osc2, 0);
        check("rst_env2", envo2, 0);
        check("rst_voice4", v4, 0);
        check("rst_audio4", audio4, 0);

        // Frame on the 2-SID instance with captures and two audio slots.
        @(posedge clk); #1 phi2_2 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 22; i++) tq2.push_back(trace_t'{V2_TAB[i], F2_TAB[i]});
        aq2.push_back(aud_t'{96'h1234500ABCD0, 5'd14});
        for (int i = 0; i < 22; i++) begin
            wav = 12'hFFF; env = 8'hFF; filter_o = 20'hFFFFF;
            if (i == 7)  begin wav = 12'hFA5; env = 8'h7E; end
            if (i == 12) begin wav = 12'h013; env = 8'h01; end
            if (i == 14) filter_o = 20'h12345;
            if (i == 19) filter_o = 20'h0ABCD;
            if (i == 2)  phi2_2 = 1'b1;
            @(posedge clk); #1;
        end

        sid_cs2 = 2'b01; @(negedge clk);
        check("rb_cs01_osc", osc2, 8'hFA);
        check("rb_cs01_env", envo2, 8'h7E);
        sid_cs2 = 2'b10; @(negedge clk);
        check("rb_cs10_osc", osc2, 8'h01);
        check("rb_cs10_env", envo2, 8'h01);
        sid_cs2 = 2'b00; @(negedge clk);
        check("rb_cs00_osc", osc2, 8'hFA);
        check("rb_cs00_env", envo2, 8'h7E);
        sid_cs2 = 2'b11; @(negedge clk);
        check("rb_cs11_osc", osc2, 8'hFA);
        check("overrun_clean_frame", ovr2, 0);

        // phi2 falls again mid-frame.
        @(posedge clk); #1 phi2_2 = 1'b0; filter_o = 20'h55555;
        aq2.push_back(aud_t'{96'h555550555550, 5'd14});
        repeat (2) @(posedge clk);
        #1 phi2_2 = 1'b1;
        n = 0;
        @(negedge clk);
        while (v2 !== 5'd10 && n < 60) begin @(negedge clk); n++; end
        check("wait_voice10", v2, 5'd10);
        phi2_2 = 1'b0;
        @(negedge clk);
        check("reload_voice", v2, 5'd1);
        check("overrun_set", ovr2, 1);
        check("filter_runs_on", f2, 5'd7);
        phi2_2 = 1'b1;
        repeat (6) @(negedge clk);
        check("filter_ignores_v6", f2, 5'd13);
        check("voice_after_v6", v2, 5'd7);
        repeat (20) @(negedge clk);
        check("voice_idle_after", v2, 5'd0);
        check("overrun_sticky", ovr2, 1);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("overrun_cleared_rst", ovr2, 0);

        // 1024 frames: exactly one tick_ms, on the last voice start.
        filter_o = 20'h0000F;
        tick_en = 1'b1;
        for (int fr = 0; fr < 1024; fr++) begin
            @(posedge clk); #1 phi2_2 = 1'b0;
            aq2.push_back(aud_t'{96'h0000F00000F0, 5'd14});
            repeat (2) @(posedge clk);
            #1 phi2_2 = 1'b1;
            repeat (21) @(posedge clk);
        end
        @(negedge clk);
        tick_en = 1'b0;
        check("tick_starts", starts, 1024);
        check("tick_count", tick_cnt, 1);
        check("tick_on_1024th", tick_at, 1024);
        check("tick_outside_v1", bad_tick, 0);
        check("overrun_paced_frames", ovr2, 0);

        // 4-SID instance: three stall windows, none at filter 19/20.
        @(posedge clk); #1 phi2_4 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 37; i++) tq4.push_back(trace_t'{V4_TAB[i], F4_TAB[i]});
        aq4.push_back(aud_t'{96'h111110222220333330444440, 5'd24});
        for (int i = 0; i < 37; i++) begin
            wav = 12'hFFF; env = 8'hFF; filter_o = 20'hFFFFF;
            if (i == 17) begin wav = 12'hC3A; env = 8'h3C; end
            if (i == 22) begin wav = 12'h5A0; env = 8'hA5; end
            if (i == 14) filter_o = 20'h11111;
            if (i == 19) filter_o = 20'h22222;
            if (i == 24) filter_o = 20'h33333;
            if (i == 29) filter_o = 20'h44444;
            if (i == 2)  phi2_4 = 1'b1;
            @(posedge clk); #1;
        end
        sid_cs4 = 4'b1100; @(negedge clk);
        check("rb4_cs1100_osc", osc4, 8'hC3);
        check("rb4_cs1100_env", envo4, 8'h3C);
        sid_cs4 = 4'b1000; @(negedge clk);
        check("rb4_cs1000_osc", osc4, 8'h5A);
        check("rb4_cs1000_env", envo4, 8'hA5);
        check("overrun4_clean", ovr4, 0);

        // Reset mid-frame at filter 12: frame aborted, no audio.
        @(posedge clk); #1 phi2_4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 phi2_4 = 1'b1;
        n = 0;
        @(negedge clk);
        while (f4 !== 5'd12 && n < 60) begin @(negedge clk); n++; end
        check("wait_filter12", f4, 5'd12);
        rst = 1'b1;
        @(negedge clk);
        check("rst4_voice", v4, 0);
        check("rst4_filter", f4, 0);
        check("rst4_audio", audio4, 0);
        check("rst4_valid", av4, 0);
        check("rst4_osc", osc4, 0);
        check("rst4_env", envo4, 0);
        check("rst4_overrun", ovr4, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst4_voice", v4, 0);
        check("post_rst4_filter", f4, 0);

        check("drain_audio2", aq2.size(), 0);
        check("drain_audio4", aq4.size(), 0);
        check("drain_trace2", tq2.size(), 0);
        check("drain_trace4", tq4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
